// File: rtl/serial_twos_comp_word_if.sv
// Bit-serial word link: serial input with valid and per-word mode, serial and
// parallel result with framing and status back.
interface serial_twos_comp_word_if #(
  parameter int WIDTH = 8
);
  logic             i;
  logic             i_vld;
  logic             neg;
  logic             y;
  logic             y_vld;
  logic             y_last;
  logic [WIDTH-1:0] y_word;
  logic             ovf;
  logic             busy;

  // Source side: drives the serial stream, observes results.
  modport master (
    output i, i_vld, neg,
    input  y, y_vld, y_last, y_word, ovf, busy
  );

  // Complementer side.
  modport slave (
    input  i, i_vld, neg,
    output y, y_vld, y_last, y_word, ovf, busy
  );
endinterface

// File: rtl/serial_twos_comp_word.sv
// Bit-serial, LSB-first two's complementer with WIDTH-bit word framing.
// Each word re-arms automatically; the mode (pass/negate) is latched on bit 0.
// Negation copies bits up to and including the first 1, then inverts the rest.
module serial_twos_comp_word #(
  parameter int WIDTH = 8
) (
  input  logic                  t_clk,
  input  logic                  r,
  serial_twos_comp_word_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic {IDLE, BUSY} state_t;

  logic [CW-1:0]    r_cnt;
  logic             r_seen;
  logic             r_mode;
  logic             r_y;
  logic             r_y_vld;
  logic             r_y_last;
  logic [WIDTH-1:0] r_y_word;
  logic             r_ovf;
  logic [WIDTH-2:0] r_sh;

  state_t           w_state;
  logic             w_m;
  logic             w_s;
  logic             w_bit;
  logic             w_last;
  logic [CW-1:0]    w_cnt_nxt;
  logic             w_seen_nxt;
  logic             w_mode_nxt;
  logic             w_y_nxt;
  logic             w_y_vld_nxt;
  logic             w_y_last_nxt;
  logic [WIDTH-1:0] w_y_word_nxt;
  logic             w_ovf_nxt;
  logic [WIDTH-2:0] w_sh_nxt;

  // Effective mode/seen: bit 0 of a word uses the live neg input and a clear seen.
  always_comb begin
    w_state = (r_cnt == '0) ? IDLE : BUSY;
    w_m     = (w_state == IDLE) ? bus.neg : r_mode;
    w_s     = (w_state == IDLE) ? 1'b0    : r_seen;
    w_bit   = bus.i ^ (w_m & w_s);
    w_last  = (r_cnt == CW'(WIDTH - 1));
  end

  // Next-state and output decode for accepted bits and gaps.
  // NOTE: every variable gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    w_cnt_nxt    = r_cnt;
    w_seen_nxt   = r_seen;
    w_mode_nxt   = r_mode;
    w_y_nxt      = r_y;
    w_y_vld_nxt  = 1'b0;
    w_y_last_nxt = 1'b0;
    w_y_word_nxt = r_y_word;
    w_ovf_nxt    = r_ovf;
    w_sh_nxt     = r_sh;
    if (bus.i_vld) begin
      w_mode_nxt  = w_m;
      w_y_nxt     = w_bit;
      w_y_vld_nxt = 1'b1;
      if (w_last) begin
        w_cnt_nxt    = '0;
        w_seen_nxt   = 1'b0;
        w_y_last_nxt = 1'b1;
        w_y_word_nxt = {w_bit, r_sh};
        // Only 100..0 (MSB-first) negates onto itself.
        w_ovf_nxt    = w_m & ~w_s & bus.i;
      end else begin
        w_cnt_nxt  = r_cnt + 1'b1;
        w_seen_nxt = w_s | bus.i;
        for (int k = 0; k < WIDTH - 1; k++) begin
          if (r_cnt == CW'(k)) w_sh_nxt[k] = w_bit;
        end
      end
    end
  end

  // Framing, mode and result registers; reset wins over an accepted bit.
  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge t_clk) begin
    if (r) begin
      r_cnt    <= '0;
      r_seen   <= 1'b0;
      r_mode   <= 1'b0;
      r_y      <= 1'b0;
      r_y_vld  <= 1'b0;
      r_y_last <= 1'b0;
      r_y_word <= '0;
      r_ovf    <= 1'b0;
    end else begin
      r_cnt    <= w_cnt_nxt;
      r_seen   <= w_seen_nxt;
      r_mode   <= w_mode_nxt;
      r_y      <= w_y_nxt;
      r_y_vld  <= w_y_vld_nxt;
      r_y_last <= w_y_last_nxt;
      r_y_word <= w_y_word_nxt;
      r_ovf    <= w_ovf_nxt;
    end
  end

  // Shadow of the low result bits, assembled into y_word at end of word.
  // NOTE: no reset here -- every shadow bit is rewritten within a word before y_word reads it.
  always_ff @(posedge t_clk) begin
    r_sh <= w_sh_nxt;
  end

  assign bus.y      = r_y;
  assign bus.y_vld  = r_y_vld;
  assign bus.y_last = r_y_last;
  assign bus.y_word = r_y_word;
  assign bus.ovf    = r_ovf;
  assign bus.busy   = (w_state == BUSY);
endmodule

// File: tb/tb_serial_twos_comp_word.sv
// Self-checking bench: WIDTH=4 and WIDTH=8 instances share one input stream;
// the active width selects which one is checked against a word-level model.
module tb_serial_twos_comp_word;
  logic t_clk = 1'b0;
  always #5 t_clk = ~t_clk;

  logic d_r   = 1'b1;
  logic d_i   = 1'b0;
  logic d_vld = 1'b0;
  logic d_neg = 1'b0;

  serial_twos_comp_word_if #(.WIDTH(4)) if4 ();
  serial_twos_comp_word_if #(.WIDTH(8)) if8 ();

  assign if4.i     = d_i;
  assign if4.i_vld = d_vld;
  assign if4.neg   = d_neg;
  assign if8.i     = d_i;
  assign if8.i_vld = d_vld;
  assign if8.neg   = d_neg;

  serial_twos_comp_word #(.WIDTH(4)) dut4 (.t_clk(t_clk), .r(d_r), .bus(if4));
  serial_twos_comp_word #(.WIDTH(8)) dut8 (.t_clk(t_clk), .r(d_r), .bus(if8));

  int errors = 0;
  int checks = 0;
  int cur_w  = 4;

  // Observed outputs of the instance under check.
  logic        o_y, o_vld, o_last, o_ovf, o_busy;
  logic [31:0] o_word;
  always_comb begin
    if (cur_w == 8) begin
      o_y = if8.y; o_vld = if8.y_vld; o_last = if8.y_last;
      o_ovf = if8.ovf; o_busy = if8.busy; o_word = 32'(if8.y_word);
    end else begin
      o_y = if4.y; o_vld = if4.y_vld; o_last = if4.y_last;
      o_ovf = if4.ovf; o_busy = if4.busy; o_word = 32'(if4.y_word);
    end
  end

  // Word-level model: partial input word and its mode; result bit k is bit k of
  // (mode ? -acc : acc), which depends only on input bits 0..k.
  int          m_pos;
  logic        m_mode;
  logic [63:0] m_acc;
  logic        e_y, e_vld, e_last, e_ovf, e_busy;
  logic [31:0] e_word;

  task automatic step(input logic vld, input logic b, input logic n, input string tag);
    logic [63:0] res;
    logic [63:0] mask;
    d_r = 1'b0; d_vld = vld; d_i = b; d_neg = n;
    @(posedge t_clk); #1;
    if (vld) begin
      if (m_pos == 0) begin
        m_mode = n;
        m_acc  = '0;
      end
      m_acc  = m_acc | (64'(b) << m_pos);
      res    = m_mode ? (64'd0 - m_acc) : m_acc;
      e_y    = res[m_pos];
      e_vld  = 1'b1;
      e_last = (m_pos == cur_w - 1);
      if (e_last) begin
        mask   = (64'd1 << cur_w) - 64'd1;
        e_word = 32'(res & mask);
        e_ovf  = m_mode && (m_acc == (64'd1 << (cur_w - 1)));
        m_pos  = 0;
      end else begin
        m_pos++;
      end
    end else begin
      e_vld  = 1'b0;
      e_last = 1'b0;
    end
    e_busy = (m_pos != 0);
    checks += 6;
    if (o_y !== e_y) begin errors++; $display("FAIL %s y: got %b expected %b", tag, o_y, e_y); end
    if (o_vld !== e_vld) begin errors++; $display("FAIL %s y_vld: got %b expected %b", tag, o_vld, e_vld); end
    if (o_last !== e_last) begin errors++; $display("FAIL %s y_last: got %b expected %b", tag, o_last, e_last); end
    if (o_word !== e_word) begin errors++; $display("FAIL %s y_word: got %h expected %h", tag, o_word, e_word); end
    if (o_ovf !== e_ovf) begin errors++; $display("FAIL %s ovf: got %b expected %b", tag, o_ovf, e_ovf); end
    if (o_busy !== e_busy) begin errors++; $display("FAIL %s busy: got %b expected %b", tag, o_busy, e_busy); end
  endtask

  // Feeds one word LSB first with up to max_gap idle cycles before each bit;
  // neg is randomised on every cycle except bit 0.
  task automatic send_word(input logic [31:0] w, input logic n, input int max_gap, input string tag);
    for (int k = 0; k < cur_w; k++) begin
      int g;
      g = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
      for (int j = 0; j < g; j++) step(1'b0, 1'($urandom), 1'($urandom), tag);
      step(1'b1, w[k], (k == 0) ? n : 1'($urandom), tag);
    end
  endtask

  // Reset with a valid bit present (it must be dropped); all outputs must be 0.
  task automatic test_reset(input string tag);
    d_r = 1'b1; d_vld = 1'b1; d_i = 1'b1; d_neg = 1'b1;
    @(posedge t_clk); #1;
    d_r = 1'b0; d_vld = 1'b0; d_i = 1'b0;
    m_pos = 0; m_mode = 1'b0; m_acc = '0;
    e_y = 1'b0; e_vld = 1'b0; e_last = 1'b0; e_word = '0; e_ovf = 1'b0; e_busy = 1'b0;
    checks += 6;
    if (o_y !== 1'b0) begin errors++; $display("FAIL %s y: got %b expected 0", tag, o_y); end
    if (o_vld !== 1'b0) begin errors++; $display("FAIL %s y_vld: got %b expected 0", tag, o_vld); end
    if (o_last !== 1'b0) begin errors++; $display("FAIL %s y_last: got %b expected 0", tag, o_last); end
    if (o_word !== 32'd0) begin errors++; $display("FAIL %s y_word: got %h expected 0", tag, o_word); end
    if (o_ovf !== 1'b0) begin errors++; $display("FAIL %s ovf: got %b expected 0", tag, o_ovf); end
    if (o_busy !== 1'b0) begin errors++; $display("FAIL %s busy: got %b expected 0", tag, o_busy); end
  endtask

  task automatic test_negate_basic();
    send_word(32'b0110, 1'b1, 0, "neg_0110");
    checks++;
    if (o_word !== 32'b1010) begin errors++; $display("FAIL neg_0110 word: got %h expected a", o_word); end
  endtask

  task automatic test_overflow();
    send_word(32'b1000, 1'b1, 0, "ovf_1000");
    checks++;
    if (o_ovf !== 1'b1 || o_word !== 32'b1000) begin
      errors++; $display("FAIL ovf_1000: got word %h ovf %b expected word 8 ovf 1", o_word, o_ovf);
    end
    send_word(32'b0001, 1'b1, 0, "neg_0001");
    checks++;
    if (o_ovf !== 1'b0 || o_word !== 32'b1111) begin
      errors++; $display("FAIL neg_0001: got word %h ovf %b expected word f ovf 0", o_word, o_ovf);
    end
  endtask

  task automatic test_pass_mode();
    step(1'b1, 1'b1, 1'b0, "pass_0101");
    step(1'b1, 1'b0, 1'b1, "pass_0101");
    step(1'b1, 1'b1, 1'b1, "pass_0101");
    step(1'b1, 1'b0, 1'b1, "pass_0101");
    checks++;
    if (o_word !== 32'b0101 || o_ovf !== 1'b0) begin
      errors++; $display("FAIL pass_0101: got word %h ovf %b expected word 5 ovf 0", o_word, o_ovf);
    end
  endtask

  task automatic test_gaps();
    repeat (3) step(1'b0, 1'b1, 1'b0, "gap_0011");
    step(1'b1, 1'b1, 1'b1, "gap_0011");
    step(1'b1, 1'b1, 1'b0, "gap_0011");
    repeat (2) step(1'b0, 1'b0, 1'b0, "gap_0011");
    step(1'b1, 1'b0, 1'b0, "gap_0011");
    step(1'b1, 1'b0, 1'b0, "gap_0011");
    checks++;
    if (o_word !== 32'b1101) begin errors++; $display("FAIL gap_0011 word: got %h expected d", o_word); end
  endtask

  task automatic test_reset_midword();
    step(1'b1, 1'b1, 1'b1, "mid_rst");
    step(1'b1, 1'b0, 1'b1, "mid_rst");
    test_reset("mid_rst_clear");
    send_word(32'b0010, 1'b1, 0, "after_rst_0010");
    checks++;
    if (o_word !== 32'b1110) begin errors++; $display("FAIL after_rst_0010 word: got %h expected e", o_word); end
  endtask

  task automatic test_back_to_back();
    cur_w = 8;
    test_reset("w8_reset");
    send_word(32'h01, 1'b1, 0, "w8_01");
    checks++;
    if (o_word !== 32'hFF || o_ovf !== 1'b0) begin
      errors++; $display("FAIL w8_01: got word %h ovf %b expected word ff ovf 0", o_word, o_ovf);
    end
    send_word(32'h80, 1'b1, 0, "w8_80");
    checks++;
    if (o_word !== 32'h80 || o_ovf !== 1'b1) begin
      errors++; $display("FAIL w8_80: got word %h ovf %b expected word 80 ovf 1", o_word, o_ovf);
    end
  endtask

  task automatic test_random(input int width, input int words);
    cur_w = width;
    test_reset("rand_reset");
    for (int n = 0; n < words; n++) begin
      logic [31:0] w;
      w = $urandom & ((32'd1 << width) - 32'd1);
      // Boundary values show up often enough to matter.
      if (n % 7 == 0) w = 32'd1 << (width - 1);
      if (n % 11 == 0) w = 32'd0;
      send_word(w, 1'($urandom), (n % 3 == 0) ? 0 : 2, "rand");
    end
  endtask

  initial begin
    cur_w = 4;
    test_reset("reset");
    test_negate_basic();
    test_overflow();
    test_pass_mode();
    test_gaps();
    test_reset_midword();
    test_back_to_back();
    test_random(4, 60);
    test_random(8, 40);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/serial_twos_comp_word.md
Name: serial_twos_comp_word

Overview:
- Bit-serial, LSB-first two's complementer with word framing: WIDTH bits per word, automatic re-arm at every word boundary, no external reset needed between words.
- Per-word mode select: pass-through or negate.
- Valid qualifier on the input allows gaps in the bit stream.
- Outputs the serial result, an assembled parallel word, an end-of-word strobe and a negation-overflow flag.
- Sits behind the serial input shifter in the bit-serial arithmetic datapath, in place of the single-stream, manually reset inverter.

Parameters:
- WIDTH, 8, bits per word; legal range 2..32.

Ports:
- t_clk  input  1  system clock; all state updates on the rising edge.
- r  input  1  reset, synchronous, active-high.
- i  input  1  serial data bit, LSB first.
- i_vld  input  1  i is valid this cycle; the bit is accepted when high.
- neg  input  1  mode: 1 = negate word, 0 = pass; sampled only on the first bit of a word.
- y  output  1  serial result bit, registered.
- y_vld  output  1  y carries a new bit this cycle.
- y_last  output  1  y is bit WIDTH-1 (MSB) of the current word.
- y_word  output  WIDTH  last complete result word, LSB at bit 0.
- ovf  output  1  last word was negated and its input was the most-negative value.
- busy  output  1  a word is partially received (cnt != 0).

Behaviour:
- Reset (r=1 at a rising edge) clears everything: y=0, y_vld=0, y_last=0, y_word=0, ovf=0, busy=0, cnt=0, seen=0, mode_q=0. Reset has priority over i_vld.
- Internal state:
  - cnt[$clog2(WIDTH)-1:0]: bit index, 0..WIDTH-1.
  - seen: a 1 has been received in the current word.
  - mode_q: latched mode for the current word.
- States: IDLE (cnt==0) and BUSY (cnt!=0). busy = (cnt!=0).
- Accepted bit (i_vld=1), next edge:
  - Effective mode m = neg if cnt==0, otherwise mode_q. If cnt==0, mode_q <= neg.
  - Effective seen s = 0 if cnt==0, otherwise seen.
  - y <= i ^ (m & s); y_vld <= 1.
  - seen <= s | i.
  - A shadow register sh[cnt] <= i ^ (m & s).
- End of word: an accepted bit with cnt==WIDTH-1, next edge:
  - y_last <= 1; cnt <= 0; seen <= 0.
  - y_word <= {result MSB, sh[WIDTH-2:0]}.
  - ovf <= m & ~s & i (input was 1 followed by WIDTH-1 zeros in MSB-first order, i.e. -2^(WIDTH-1)).
- Otherwise an accepted bit gives cnt <= cnt+1 and y_last <= 0.
- Gap (i_vld=0):
  - y_vld <= 0 and y_last <= 0.
  - y, cnt, seen, mode_q, y_word and ovf hold.
  - Gaps may occur anywhere in a word, including before the first bit and before the MSB.
- Latency: exactly 1 cycle from an accepted bit to its y/y_vld. y_word and ovf update on the same edge as y_last.
- y_word and ovf hold until the next end of word or reset. They are not cleared at word start.
- Pass mode: y = i bit-for-bit; y_word = input word; ovf = 0.
- Negate of zero: output is 0, ovf=0.
- neg changes mid-word have no effect on the current word.
- Back-to-back words need no idle cycle: the bit after y_last's source bit is bit 0 of the next word, with fresh mode and seen.
- Reset mid-word: the partial word is discarded; y_word and ovf go to 0. The next accepted bit is bit 0.
- An i_vld=1 bit coinciding with r=1 is dropped.

Test Plan (WIDTH=4 unless noted):
- Reset, then word 0110 (bits 0,1,1,0 LSB first, neg=1, contiguous) -> y = 0,1,0,1 on the 4 cycles after each bit; y_vld high for 4 cycles; y_last on the 4th; y_word=4'b1010; ovf=0; busy high after bits 1-3.
- Word 1000 (bits 0,0,0,1, neg=1) -> y = 0,0,0,1; y_word=4'b1000; ovf=1. The next word 0001 negated -> y_word=4'b1111, ovf=0.
- Word 0101 with neg=0, with neg toggled to 1 after bit 0 -> y = 1,0,1,0 (pass); y_word=4'b0101; ovf=0.
- Word 0011 (neg=1) with 2 idle cycles between bits 1 and 2 and 3 idle cycles before bit 0 -> y_word=4'b1101; y_vld low during gaps; y holds its last value during gaps.
- Two bits of a word, then r=1 for one cycle, then word 0010 (neg=1) -> all outputs 0 after reset; the following word gives y_word=4'b1110 with y_last on its own 4th bit.
- WIDTH=8, back-to-back words 8'h01 and 8'h80 with neg=1 -> y_word=8'hFF, ovf=0, then y_word=8'h80, ovf=1; y_last on cycles 8 and 16 after the first bit.
